// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/execute Moore FSM for the 8-bit accumulator CPU.
// Optional SINGLE_STEP_EN macro adds a step input and a PAUSE state after each retired instruction.
module ctrl_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             LD,
    input  logic             ADD,
    input  logic             SUB,
    input  logic             AND,
    input  logic             OR,
    input  logic             STO,
    input  logic             HALT,
    input  logic             mem_rdy,
    output logic             IIR,
    output logic             mar_ld,
    output logic             mar_sel,
    output logic             pc_inc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             acc_ld,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    // Wait counter only ever holds 0..TIMEOUT-1; the FSM leaves the state on the last count.
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        F_MAR  = 4'd1,
        F_RD   = 4'd2,
        F_LAT  = 4'd3,
        DEC    = 4'd4,
        E_MAR  = 4'd5,
        E_MEM  = 4'd6,
        E_WB   = 4'd7,
        HALTED = 4'd8,
        FAULT  = 4'd9,
        PAUSE  = 4'd10
    } state_t;

    state_t            state_q, state_n;
    logic [WAIT_W-1:0] wait_q, wait_n;
    logic [2:0]        alu_q, alu_n;
    logic              sto_q, sto_n;
    logic              cnt_inc;
    logic [CNT_W-1:0]  cnt_n;

    logic       iir_n, mar_ld_n, mar_sel_n, pc_inc_n, mem_rd_n, mem_wr_n, acc_ld_n;
    logic       halted_n, fault_n;
    logic [2:0] alu_op_n;

    logic [6:0] dec_c;
    logic       dec_ok_c;
    logic [2:0] alu_dec_c;

    assign dec_c    = {HALT, STO, OR, AND, SUB, ADD, LD};
    assign dec_ok_c = $onehot(dec_c);

    // Opcode to ALU function; LD and STO both map to pass.
    always_comb begin
        alu_dec_c = ALU_PASS;
        if (ADD)      alu_dec_c = ALU_ADD;
        else if (SUB) alu_dec_c = ALU_SUB;
        else if (AND) alu_dec_c = ALU_AND;
        else if (OR)  alu_dec_c = ALU_OR;
    end

    // Next state, then registered outputs derived from the state being entered.
    always_comb begin
        state_n = state_q;
        wait_n  = '0;
        alu_n   = alu_q;
        sto_n   = sto_q;
        cnt_inc = 1'b0;

        case (state_q)
            IDLE:   if (start) state_n = F_MAR;
            F_MAR:  state_n = F_RD;
            F_RD: begin
                if (mem_rdy)                state_n = F_LAT;
                else if (wait_q == WAIT_LAST) state_n = FAULT;
                else                        wait_n  = wait_q + WAIT_W'(1);
            end
            F_LAT:  state_n = DEC;
            DEC: begin
                if (!dec_ok_c) begin
                    state_n = FAULT;
                end else if (HALT) begin
                    state_n = HALTED;
                    cnt_inc = 1'b1;
                end else begin
                    state_n = E_MAR;
                    alu_n   = alu_dec_c;
                    sto_n   = STO;
                end
            end
            E_MAR:  state_n = E_MEM;
            E_MEM: begin
                if (mem_rdy)                state_n = E_WB;
                else if (wait_q == WAIT_LAST) state_n = FAULT;
                else                        wait_n  = wait_q + WAIT_W'(1);
            end
            E_WB: begin
                cnt_inc = 1'b1;
`ifdef SINGLE_STEP_EN
                state_n = PAUSE;
`else
                state_n = F_MAR;
`endif
            end
`ifdef SINGLE_STEP_EN
            PAUSE:  if (step) state_n = F_MAR;
`endif
            HALTED: state_n = HALTED;
            FAULT:  state_n = FAULT;
            default: state_n = IDLE;
        endcase

        iir_n     = 1'b0;
        mar_ld_n  = 1'b0;
        mar_sel_n = 1'b0;
        pc_inc_n  = 1'b0;
        mem_rd_n  = 1'b0;
        mem_wr_n  = 1'b0;
        acc_ld_n  = 1'b0;
        alu_op_n  = ALU_PASS;
        halted_n  = 1'b0;
        fault_n   = 1'b0;

        case (state_n)
            F_MAR: mar_ld_n = 1'b1;
            F_RD: begin
                mem_rd_n = 1'b1;
                iir_n    = 1'b1;
            end
            F_LAT: pc_inc_n = 1'b1;
            E_MAR: begin
                mar_ld_n  = 1'b1;
                mar_sel_n = 1'b1;
                alu_op_n  = alu_n;
            end
            E_MEM: begin
                mem_wr_n = sto_n;
                mem_rd_n = !sto_n;
                alu_op_n = alu_n;
            end
            E_WB: begin
                acc_ld_n = !sto_n;
                alu_op_n = alu_n;
            end
            HALTED: halted_n = 1'b1;
            FAULT:  fault_n  = 1'b1;
            default: ;
        endcase

        cnt_n = (cnt_inc && (instr_cnt != '1)) ? instr_cnt + CNT_W'(1) : instr_cnt;
    end

    // State, wait counter, latched opcode and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            alu_q     <= ALU_PASS;
            sto_q     <= 1'b0;
            IIR       <= 1'b0;
            mar_ld    <= 1'b0;
            mar_sel   <= 1'b0;
            pc_inc    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            acc_ld    <= 1'b0;
            alu_op    <= ALU_PASS;
            halted    <= 1'b0;
            fault     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q   <= state_n;
            wait_q    <= wait_n;
            alu_q     <= alu_n;
            sto_q     <= sto_n;
            IIR       <= iir_n;
            mar_ld    <= mar_ld_n;
            mar_sel   <= mar_sel_n;
            pc_inc    <= pc_inc_n;
            mem_rd    <= mem_rd_n;
            mem_wr    <= mem_wr_n;
            acc_ld    <= acc_ld_n;
            alu_op    <= alu_op_n;
            halted    <= halted_n;
            fault     <= fault_n;
            instr_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a default instance and a CNT_W=2 instance share all stimulus.
// Define SINGLE_STEP_EN for both RTL and bench to exercise the PAUSE state.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

    logic clk = 1'b0;
    logic rst, start, mem_rdy, dec_extra;
`ifdef SINGLE_STEP_EN
    logic step;
`endif
    logic [2:0] ir;
    logic dec_ld, dec_add, dec_sub, dec_and, dec_or, dec_sto, dec_halt;

    logic iir_a, mar_ld_a, mar_sel_a, pc_inc_a, mem_rd_a, mem_wr_a, acc_ld_a, halted_a, fault_a;
    logic iir_b, mar_ld_b, mar_sel_b, pc_inc_b, mem_rd_b, mem_wr_b, acc_ld_b, halted_b, fault_b;
    logic [2:0]  alu_op_a, alu_op_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [11:0] obs_a, obs_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Opcode encoding used by the bench: 0 LD,1 ADD,2 SUB,3 AND,4 OR,5 STO,6 HALT,7 none.
    assign dec_ld   = (ir == 3'd0);
    assign dec_add  = (ir == 3'd1) | dec_extra;
    assign dec_sub  = (ir == 3'd2);
    assign dec_and  = (ir == 3'd3);
    assign dec_or   = (ir == 3'd4);
    assign dec_sto  = (ir == 3'd5);
    assign dec_halt = (ir == 3'd6);

    assign obs_a = {iir_a, mar_ld_a, mar_sel_a, pc_inc_a, mem_rd_a, mem_wr_a, acc_ld_a, alu_op_a, halted_a, fault_a};
    assign obs_b = {iir_b, mar_ld_b, mar_sel_b, pc_inc_b, mem_rd_b, mem_wr_b, acc_ld_b, alu_op_b, halted_b, fault_b};

    ctrl_sequencer #(.TIMEOUT(15), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .LD(dec_ld), .ADD(dec_add), .SUB(dec_sub), .AND(dec_and), .OR(dec_or),
        .STO(dec_sto), .HALT(dec_halt), .mem_rdy(mem_rdy),
        .IIR(iir_a), .mar_ld(mar_ld_a), .mar_sel(mar_sel_a), .pc_inc(pc_inc_a),
        .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .acc_ld(acc_ld_a), .alu_op(alu_op_a),
        .halted(halted_a), .fault(fault_a), .instr_cnt(cnt_a)
    );

    ctrl_sequencer #(.TIMEOUT(15), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .start(start),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .LD(dec_ld), .ADD(dec_add), .SUB(dec_sub), .AND(dec_and), .OR(dec_or),
        .STO(dec_sto), .HALT(dec_halt), .mem_rdy(mem_rdy),
        .IIR(iir_b), .mar_ld(mar_ld_b), .mar_sel(mar_sel_b), .pc_inc(pc_inc_b),
        .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .acc_ld(acc_ld_b), .alu_op(alu_op_b),
        .halted(halted_b), .fault(fault_b), .instr_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] vec(input logic iir, input logic mld, input logic msel,
                                        input logic pinc, input logic mrd, input logic mwr,
                                        input logic ald, input logic [2:0] alu,
                                        input logic hlt, input logic flt);
        return {iir, mld, msel, pinc, mrd, mwr, ald, alu, hlt, flt};
    endfunction

    // Check both instances' strobes at this negedge, then advance one cycle.
    task automatic cyc(input string tag, input logic [11:0] exp);
        check({tag, " a"}, 32'(obs_a), 32'(exp));
        check({tag, " b"}, 32'(obs_b), 32'(exp));
        @(negedge clk);
    endtask

    task automatic cnt_check(input string tag, input int exp_a, input int exp_b);
        check({tag, " cnt"}, 32'(cnt_a), 32'(exp_a));
        check({tag, " cnt small"}, 32'(cnt_b), 32'(exp_b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fetch(input logic [2:0] op);
        ir = op;
        cyc("f_mar", vec(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        cyc("f_rd",  vec(1, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0));
        cyc("f_lat", vec(0, 0, 0, 1, 0, 0, 0, 3'd0, 0, 0));
        cyc("dec",   12'd0);
    endtask

    task automatic execute(input logic [2:0] alu, input logic sto);
        cyc("e_mar", vec(0, 1, 1, 0, 0, 0, 0, alu, 0, 0));
        cyc("e_mem", vec(0, 0, 0, 0, !sto, sto, 0, alu, 0, 0));
        cyc("e_wb",  vec(0, 0, 0, 0, 0, 0, !sto, alu, 0, 0));
    endtask

    task automatic resume();
`ifdef SINGLE_STEP_EN
        cyc("pause", 12'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
`endif
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] alu, input logic sto);
        fetch(op);
        execute(alu, sto);
        resume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mem_rdy = 1'b1; ir = 3'd7; dec_extra = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt_check("reset", 0, 0);
        cyc("reset", 12'd0);

        // Reset mid-fetch drops strobes asynchronously; start ignored outside IDLE.
        mem_rdy = 1'b0;
        go();
        cyc("t1 f_mar", vec(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        start = 1'b1;
        cyc("t1 f_rd", vec(1, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0));
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t1 async rst", 32'(obs_a), 32'd0);
        check("t1 async rst cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rdy = 1'b1;
        cyc("t1 idle", 12'd0);

        // LD, ADD, STO, HALT with immediate memory.
        go();
        run_instr(3'd0, 3'b000, 1'b0);
        cnt_check("t2 ld", 1, 1);
        run_instr(3'd1, 3'b001, 1'b0);
        cnt_check("t2 add", 2, 2);
        run_instr(3'd5, 3'b000, 1'b1);
        cnt_check("t2 sto", 3, 3);
        fetch(3'd6);
        start = 1'b1;
        cyc("t2 halted", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0));
        cyc("t2 halted sticky", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0));
        start = 1'b0;
        cnt_check("t2 halt", 4, 3);

        // Remaining ALU codes, then an empty decode faults.
        do_reset();
        go();
        run_instr(3'd2, 3'b010, 1'b0);
        run_instr(3'd3, 3'b011, 1'b0);
        run_instr(3'd4, 3'b100, 1'b0);
        cnt_check("t3 alu", 3, 3);
        fetch(3'd7);
        start = 1'b1;
        cyc("t3 fault", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1));
        cyc("t3 fault sticky", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1));
        start = 1'b0;
        cnt_check("t3 fault", 3, 3);

        // Two decode lines high also faults.
        do_reset();
        go();
        dec_extra = 1'b1;
        fetch(3'd0);
        cyc("t3 twohot fault", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1));
        dec_extra = 1'b0;
        cnt_check("t3 twohot", 0, 0);

        // Memory timeout in E_MEM: 15 waiting cycles then FAULT.
        do_reset();
        go();
        fetch(3'd0);
        mem_rdy = 1'b0;
        cyc("t4 e_mar", vec(0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0));
        repeat (15) cyc("t4 e_mem wait", vec(0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0));
        cyc("t4 timeout", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1));
        mem_rdy = 1'b1;
        cnt_check("t4 timeout", 0, 0);

        // mem_rdy on the 15th waiting cycle wins.
        do_reset();
        go();
        fetch(3'd0);
        mem_rdy = 1'b0;
        cyc("t4b e_mar", vec(0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0));
        repeat (14) cyc("t4b e_mem wait", vec(0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0));
        mem_rdy = 1'b1;
        cyc("t4b e_mem last", vec(0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0));
        cyc("t4b e_wb", vec(0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0));
        resume();
        cnt_check("t4b", 1, 1);

        // Counter saturation on the CNT_W=2 instance.
        do_reset();
        go();
        for (int k = 1; k <= 5; k++) begin
            run_instr(3'd1, 3'b001, 1'b0);
            cnt_check($sformatf("t5 add%0d", k), k, (k > 3) ? 3 : k);
        end
        fetch(3'd6);
        cyc("t5 halted", vec(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0));
        cnt_check("t5 halt", 6, 3);

`ifdef SINGLE_STEP_EN
        // PAUSE holds with step low; step releases to F_MAR.
        do_reset();
        go();
        fetch(3'd0);
        execute(3'b000, 1'b0);
        start = 1'b1;
        repeat (10) cyc("t6 pause", 12'd0);
        start = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cyc("t6 step f_mar", vec(0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        cnt_check("t6", 1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
